hawk_drive_timing: RTL and testbench

- Drive-side timing and positioner model for the Hawk disk interface; it answers the controller's seek commands and produces rotational index/sector timing.
- Sits directly downstream of the controller-side command logic.
- Consumes cyl_strobe/cylad and produces on_cyl, ready, seek_err, addr_ack, index, sector and sa.
- Lets the controller be exercised in simulation and on the FPGA bench without a real drive.

---
 rtl/hawk_pkg.sv | 23 ++
 rtl/hawk_rotation.sv | 52 +++++
 rtl/hawk_drive_timing.sv | 142 ++++++++++++++
 tb/tb_hawk_drive_timing.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hawk_pkg.sv
// Shared types and constants for the Hawk drive-side timing model.
package hawk_pkg;

  typedef enum logic [1:0] {
    SPINUP = 2'd0,
    IDLE   = 2'd1,
    STEP   = 2'd2,
    SETTLE = 2'd3
  } drive_state_t;

  localparam int CYL_W           = 9;
  localparam int SA_W            = 5;
  localparam int MAX_CYL_DEFAULT = 407;
  localparam int SECTORS_DEFAULT = 16;

  // Largest of three timer loads; sizes the one shared seek/spin-up timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hawk_rotation.sv
// Free-running rotational model: position counter, sector address, sector and index pulses.
module hawk_rotation
  import hawk_pkg::*;
#(
  parameter int CLKS_PER_SECTOR = 62500,
  parameter int SECTORS         = SECTORS_DEFAULT,
  parameter int PULSE_CLKS      = 40,
  parameter int INDEX_LEAD_CLKS = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            index,
  output logic            sector,
  output logic [SA_W-1:0] sa
);

  localparam int PW = $clog2(CLKS_PER_SECTOR);
  localparam logic [PW-1:0]   POS_LAST  = PW'(CLKS_PER_SECTOR - 1);
  localparam logic [PW-1:0]   PULSE_END = PW'(PULSE_CLKS - 1);
  localparam logic [PW-1:0]   IDX_START = PW'(CLKS_PER_SECTOR - INDEX_LEAD_CLKS);
  localparam logic [PW-1:0]   IDX_END   = PW'(CLKS_PER_SECTOR - INDEX_LEAD_CLKS + PULSE_CLKS);
  localparam logic [SA_W-1:0] SA_LAST   = SA_W'(SECTORS - 1);

  logic [PW-1:0] pos;
  logic          wrap;

  assign wrap = (pos == POS_LAST);

  // Position counter, sector address and sector pulse; sa advances in the wrap clk
  // so it already shows the new sector when the pulse rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos    <= '0;
      sa     <= '0;
      sector <= 1'b0;
    end else begin
      pos <= wrap ? '0 : pos + 1'b1;
      if (wrap) begin
        sa     <= (sa == SA_LAST) ? '0 : sa + 1'b1;
        sector <= 1'b1;
      end else if (pos == PULSE_END) begin
        sector <= 1'b0;
      end
    end
  end

  // Index sits in the lead window of the last sector, ahead of the sector-0 boundary.
  always_comb begin
    index = (sa == SA_LAST) && (pos >= IDX_START) && (pos < IDX_END);
  end

endmodule

// File: rtl/hawk_drive_timing.sv
// Hawk drive emulator: seek positioner FSM plus rotational timing.
//
// state  | meaning
// SPINUP | waiting for the spindle after reset; not ready
// IDLE   | ready and on cylinder; accepts seek strobes
// STEP   | moving the heads one cylinder per step period
// SETTLE | heads on target, waiting for settle time
module hawk_drive_timing
  import hawk_pkg::*;
#(
  parameter int CLKS_PER_SECTOR = 62500,
  parameter int SECTORS         = SECTORS_DEFAULT,
  parameter int PULSE_CLKS      = 40,
  parameter int INDEX_LEAD_CLKS = 1000,
  parameter int MAX_CYL         = MAX_CYL_DEFAULT,
  parameter int STEP_CLKS       = 400,
  parameter int SETTLE_CLKS     = 2000,
  parameter int SPINUP_CLKS     = 5000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hawk_cyl_strobe,
  input  logic [CYL_W-1:0] hawk_cylad,
  output logic             hawk_ready,
  output logic             hawk_on_cyl,
  output logic             hawk_addr_ack,
  output logic             hawk_seek_err,
  output logic             hawk_index,
  output logic             hawk_sector,
  output logic [SA_W-1:0]  hawk_sa,
  output logic [CYL_W-1:0] cur_cyl
);

  localparam int TMAX = max3(SPINUP_CLKS, STEP_CLKS, SETTLE_CLKS);
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0]    SPINUP_LOAD = TW'(SPINUP_CLKS - 1);
  localparam logic [TW-1:0]    STEP_LOAD   = TW'(STEP_CLKS - 1);
  localparam logic [TW-1:0]    SETTLE_LOAD = TW'(SETTLE_CLKS - 1);
  localparam logic [CYL_W-1:0] CYL_LIMIT   = CYL_W'(MAX_CYL);

  drive_state_t     state, state_nx;
  logic [TW-1:0]    tmr, tmr_nx;
  logic [CYL_W-1:0] cyl, cyl_nx;
  logic [CYL_W-1:0] tgt, tgt_nx;
  logic [CYL_W-1:0] stepped;
  logic             ack_q, ack_nx;
  logic             err_q, err_nx;

  hawk_rotation #(
    .CLKS_PER_SECTOR (CLKS_PER_SECTOR),
    .SECTORS         (SECTORS),
    .PULSE_CLKS      (PULSE_CLKS),
    .INDEX_LEAD_CLKS (INDEX_LEAD_CLKS)
  ) u_rotation (
    .clk    (clk),
    .rst_n  (rst_n),
    .index  (hawk_index),
    .sector (hawk_sector),
    .sa     (hawk_sa)
  );

  // State, timer and positioner registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SPINUP;
      tmr   <= SPINUP_LOAD;
      cyl   <= '0;
      tgt   <= '0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      tmr   <= tmr_nx;
      cyl   <= cyl_nx;
      tgt   <= tgt_nx;
      ack_q <= ack_nx;
      err_q <= err_nx;
    end
  end

  // Next-state logic; the final step hands straight to SETTLE so settle time
  // starts the clk the heads arrive.
  always_comb begin
    state_nx = state;
    tmr_nx   = tmr;
    cyl_nx   = cyl;
    tgt_nx   = tgt;
    ack_nx   = 1'b0;
    err_nx   = err_q;
    stepped  = (cyl < tgt) ? cyl + 1'b1 : cyl - 1'b1;
    case (state)
      SPINUP: begin
        if (tmr == '0) state_nx = IDLE;
        else           tmr_nx   = tmr - 1'b1;
      end
      IDLE: begin
        if (hawk_cyl_strobe) begin
          if (hawk_cylad <= CYL_LIMIT) begin
            tgt_nx   = hawk_cylad;
            ack_nx   = 1'b1;
            err_nx   = 1'b0;
            tmr_nx   = STEP_LOAD;
            state_nx = STEP;
          end else begin
            err_nx = 1'b1;
          end
        end
      end
      STEP: begin
        if (cyl == tgt) begin
          state_nx = SETTLE;
          tmr_nx   = SETTLE_LOAD;
        end else if (tmr == '0) begin
          cyl_nx = stepped;
          if (stepped == tgt) begin
            state_nx = SETTLE;
            tmr_nx   = SETTLE_LOAD;
          end else begin
            tmr_nx = STEP_LOAD;
          end
        end else begin
          tmr_nx = tmr - 1'b1;
        end
      end
      SETTLE: begin
        if (tmr == '0) state_nx = IDLE;
        else           tmr_nx   = tmr - 1'b1;
      end
      default: state_nx = SPINUP;
    endcase
  end

  // Status outputs decoded from registered state.
  always_comb begin
    hawk_ready    = (state == IDLE);
    hawk_on_cyl   = (state == IDLE);
    hawk_addr_ack = ack_q;
    hawk_seek_err = err_q;
    cur_cyl       = cyl;
  end

endmodule

// File: tb/tb_hawk_drive_timing.sv
// Scoreboard bench for hawk_drive_timing with shortened timing parameters.
module tb_hawk_drive_timing;

  localparam int CPS    = 200;
  localparam int NSEC   = 16;
  localparam int PULSE  = 5;
  localparam int LEAD   = 20;
  localparam int MAXC   = 407;
  localparam int STEPC  = 4;
  localparam int SETTLE = 8;
  localparam int SPIN   = 50;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       strobe = 1'b0;
  logic [8:0] cylad = '0;
  logic       ready, on_cyl, addr_ack, seek_err, index, sector;
  logic [4:0] sa;
  logic [8:0] cur_cyl;

  hawk_drive_timing #(
    .CLKS_PER_SECTOR (CPS),
    .SECTORS         (NSEC),
    .PULSE_CLKS      (PULSE),
    .INDEX_LEAD_CLKS (LEAD),
    .MAX_CYL         (MAXC),
    .STEP_CLKS       (STEPC),
    .SETTLE_CLKS     (SETTLE),
    .SPINUP_CLKS     (SPIN)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .hawk_cyl_strobe (strobe),
    .hawk_cylad      (cylad),
    .hawk_ready      (ready),
    .hawk_on_cyl     (on_cyl),
    .hawk_addr_ack   (addr_ack),
    .hawk_seek_err   (seek_err),
    .hawk_index      (index),
    .hawk_sector     (sector),
    .hawk_sa         (sa),
    .cur_cyl         (cur_cyl)
  );

  always #5 clk = ~clk;

  typedef struct {
    int ack_cyc;
    int rdy_cyc;
    int tgt;
  } seek_exp_t;

  seek_exp_t sb[$];
  seek_exp_t act;
  bit        active;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic ack_d, ready_d, sec_d, idx_d;
  logic [4:0] sa_d;
  int sec_rises, idx_rises, wraps, sec0_cyc, idx_fall_cyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0d expected=%0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Advance one clk, compare rotation against the model and run the seek scoreboard.
  task automatic tick();
    int         pos;
    logic [4:0] esa;
    logic       esec, eidx;
    logic [6:0] er;
    @(posedge clk);
    #1;
    cyc++;
    pos  = cyc % CPS;
    esa  = 5'((cyc / CPS) % NSEC);
    esec = (cyc >= CPS) && (pos < PULSE);
    eidx = (esa == 5'(NSEC - 1)) && (pos >= CPS - LEAD) && (pos < CPS - LEAD + PULSE);
    er   = {eidx, esec, esa};
    chk("rotation", {index, sector, sa}, er);
    if (addr_ack) begin
      if (ack_d) chk("ack_width", {ack_d, addr_ack}, 1);
      else if (sb.size() == 0) chk("ack_unexpected", addr_ack, 0);
      else begin
        act    = sb.pop_front();
        active = 1'b1;
        chk("ack_cyc", cyc, act.ack_cyc);
        chk("ack_ready_low", {ready, on_cyl}, 0);
      end
    end
    if (active && ready && !ready_d) begin
      chk("ready_cyc", cyc, act.rdy_cyc);
      chk("seek_cyl", cur_cyl, act.tgt);
      chk("seek_on_cyl", on_cyl, 1);
      active = 1'b0;
    end
    if (sector && !sec_d) begin
      sec_rises++;
      if (sa == 5'd0) sec0_cyc = cyc;
    end
    if (index && !idx_d) idx_rises++;
    if (!index && idx_d) idx_fall_cyc = cyc;
    if (sa == 5'd0 && sa_d == 5'(NSEC - 1)) wraps++;
    ack_d   = addr_ack;
    ready_d = ready;
    sec_d   = sector;
    idx_d   = index;
    sa_d    = sa;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n   = 1'b1;
    cyc     = 0;
    ack_d   = 1'b0;
    ready_d = 1'b0;
    sec_d   = 1'b0;
    idx_d   = 1'b0;
    sa_d    = 5'd0;
    active  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {ready, on_cyl, addr_ack, seek_err, index, sector}, 0);
    chk({tag, "_sa"}, sa, 0);
    chk({tag, "_cyl"}, cur_cyl, 0);
  endtask

  task automatic spinup_check(input string tag);
    while (cyc < SPIN - 1) tick();
    chk({tag, "_early"}, ready, 0);
    tick();
    chk({tag, "_ready"}, {ready, on_cyl}, 3);
    chk({tag, "_sa"}, sa, 0);
    chk({tag, "_cyl"}, cur_cyl, 0);
  endtask

  // Expected ack and ready-return cycles for a seek whose strobe is sampled on the next edge.
  task automatic push_seek(input int from, input int to, input int c);
    seek_exp_t e;
    int n;
    n = (to > from) ? to - from : from - to;
    e.ack_cyc = c + 1;
    e.rdy_cyc = (n == 0) ? c + 1 + 1 + SETTLE : c + 1 + STEPC * n + SETTLE;
    e.tgt     = to;
    sb.push_back(e);
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && !active) break;
      tick();
    end
    chk({tag, "_drained"}, (sb.size() == 0 && !active), 1);
  endtask

  initial begin
    int c;
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_async");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    release_reset();
    spinup_check("spinup");

    // Seek 0 -> 10.
    c = cyc;
    strobe = 1'b1;
    cylad  = 9'd10;
    push_seek(0, 10, c);
    tick();
    strobe = 1'b0;
    drain("seek10", 200);

    // Out-of-range strobe.
    strobe = 1'b1;
    cylad  = 9'd408;
    tick();
    strobe = 1'b0;
    chk("bad_err", seek_err, 1);
    chk("bad_ready", {ready, on_cyl}, 3);
    repeat (10) tick();
    chk("bad_cyl", cur_cyl, 10);
    chk("bad_err_sticky", seek_err, 1);

    // Valid strobe to 5 clears the error.
    c = cyc;
    strobe = 1'b1;
    cylad  = 9'd5;
    push_seek(10, 5, c);
    tick();
    strobe = 1'b0;
    chk("err_cleared", seek_err, 0);
    drain("seek5", 200);

    // Strobe held through a seek: the repeat is accepted only back in IDLE.
    c = cyc;
    strobe = 1'b1;
    cylad  = 9'd20;
    push_seek(5, 20, c);
    push_seek(20, 20, c + 1 + STEPC * 15 + SETTLE);
    for (int i = 0; i < 300; i++) begin
      tick();
      if (cyc == c + 2 + STEPC * 15 + SETTLE) strobe = 1'b0;
      if (sb.size() == 0 && !active) break;
    end
    chk("hold_drained", (sb.size() == 0 && !active), 1);
    chk("hold_strobe_dropped", strobe, 0);
    repeat (20) tick();
    chk("hold_idle", {ready, cur_cyl}, {1'b1, 9'd20});

    // One full revolution, aligned to the sector-0 boundaries.
    while (cyc < CPS * NSEC) tick();
    sec_rises = 0;
    idx_rises = 0;
    wraps     = 0;
    sec0_cyc  = -1;
    idx_fall_cyc = -1;
    repeat (CPS * NSEC) tick();
    chk("rev_sectors", sec_rises, NSEC);
    chk("rev_index", idx_rises, 1);
    chk("rev_wraps", wraps, 1);
    chk("rev_sec0_cyc", sec0_cyc, 2 * CPS * NSEC);
    chk("rev_index_first", (idx_fall_cyc >= 0) && (idx_fall_cyc < sec0_cyc), 1);

    // Reset in the middle of a seek.
    c = cyc;
    strobe = 1'b1;
    cylad  = 9'd0;
    push_seek(20, 0, c);
    tick();
    strobe = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (cur_cyl == 9'd3) break;
      tick();
    end
    chk("mid_seek_cyl", cur_cyl, 3);
    chk("mid_seek_busy", ready, 0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset_mid");
    sb.delete();
    active = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_held");
    release_reset();
    spinup_check("respin");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
